// File: rtl/prog_mem_if.sv
// Fetch and load bus of the program memory. The CPU/loader side is the
// master; prog_mem is the slave.
interface prog_mem_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              hold;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic [ADDR_W:0]   loaded_len;

  modport master (
    output addr, load_start, load_valid, load_data, load_last,
    input  data, hold, load_ready, loaded_len
  );

  modport slave (
    input  addr, load_start, load_valid, load_data, load_last,
    output data, hold, load_ready, loaded_len
  );
endinterface

// File: rtl/prog_mem.sv
// Program memory. It clears itself after reset, serves registered
// instruction fetches in RUN, and is reprogrammed through a valid/ready
// load stream. While the memory is being cleared or loaded, hold stalls
// the CPU and the fetch output is forced to zero (a NOP).
module prog_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic       clk,
  input  logic       n_reset,
  prog_mem_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {CLEAR, RUN, LOAD} state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] wptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              xfer;
  logic              last_word;
  logic              clr_done;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // A load word is accepted only in LOAD. The load ends on load_last or when
  // the top location is written, so the pointer never wraps.
  assign xfer      = (state == LOAD) && bus.load_valid;
  assign last_word = xfer && (bus.load_last || (wptr == ADDR_W'(DEPTH - 1)));
  assign clr_done  = (clr_cnt == ADDR_W'(DEPTH - 1));

  assign bus.hold       = (state != RUN);
  assign bus.load_ready = (state == LOAD);

  // Next-state logic. load_start is honoured only from RUN.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    next_state = state;
    unique case (state)
      CLEAR:   if (clr_done) next_state = RUN;
      RUN:     if (bus.load_start) next_state = LOAD;
      LOAD:    if (last_word) next_state = RUN;
      default: next_state = CLEAR;
    endcase
  end

  // State register. Reset forces CLEAR so that an aborted load is wiped.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
    if (!n_reset) state <= CLEAR;
    else          state <= next_state;
  end

  // Clear counter, write pointer and the completed-load length.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      clr_cnt        <= '0;
      wptr           <= '0;
      bus.loaded_len <= '0;
    end else begin
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if ((state == RUN) && bus.load_start) wptr <= '0;
      else if (xfer)                        wptr <= wptr + 1'b1;
      if (last_word) bus.loaded_len <= {1'b0, wptr} + (ADDR_W + 1)'(1);
    end
  end

  // One write port, shared by the clear sweep and load transfers. Writes
  // are blocked during reset so that reset takes priority over a load word.
  always_comb begin
    wr_en   = n_reset && ((state == CLEAR) || xfer);
    wr_addr = (state == CLEAR) ? clr_cnt : wptr;
    wr_data = (state == CLEAR) ? '0 : bus.load_data;
  end

  // Storage array.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; the CLEAR sweep after every reset zeroes it.
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered fetch. The read runs only in RUN, and writes happen only
  // outside RUN, so a read never meets a write to the same location.
  always_ff @(posedge clk) begin
    if (!n_reset)          bus.data <= '0;
    else if (state == RUN) bus.data <= mem[bus.addr];
    else                   bus.data <= '0;
  end
endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem. A reference image of the memory is
// kept in model[]. Each fetch pushes its expected word when the address is
// driven, and the word is popped and compared one cycle later.
module tb_prog_mem;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic n_reset = 1'b0;

  prog_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  prog_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] load_words [$];

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.addr       = '0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
  endtask

  // One reset edge, followed by a check of every reset value.
  task automatic apply_reset();
    n_reset = 1'b0;
    tick();
    tests++; if (bus.hold !== 1'b1) begin fails++; $display("FAIL reset_hold: got %b, expected 1", bus.hold); end
    tests++; if (bus.load_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b, expected 0", bus.load_ready); end
    tests++; if (bus.data !== '0) begin fails++; $display("FAIL reset_data: got %h, expected 00", bus.data); end
    tests++; if (bus.loaded_len !== '0) begin fails++; $display("FAIL reset_len: got %0d, expected 0", bus.loaded_len); end
    n_reset = 1'b1;
  endtask

  // Counts CLEAR cycles after reset release; optionally pulses load_start
  // during CLEAR, which must not change the sweep length.
  task automatic run_clear(input int pulse_at);
    int cnt = 0;
    while (bus.hold === 1'b1 && cnt < 64) begin
      bus.load_start = (cnt == pulse_at);
      tick();
      cnt++;
    end
    bus.load_start = 1'b0;
    tests++; if (cnt != DEPTH) begin fails++; $display("FAIL clear_len: got %0d cycles, expected %0d", cnt, DEPTH); end
    tests++; if (bus.load_ready !== 1'b0) begin fails++; $display("FAIL clear_ready: got %b, expected 0", bus.load_ready); end
    tests++; if (bus.data !== '0) begin fails++; $display("FAIL clear_nop: got %h, expected 00", bus.data); end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Fetch every address in turn, comparing each word one cycle later.
  task automatic read_all(input string tag);
    logic [DATA_W-1:0] exp;
    for (int a = 0; a < DEPTH; a++) begin
      bus.addr = ADDR_W'(a);
      exp_q.push_back(model[a]);
      tick();
      exp = exp_q.pop_front();
      tests++;
      if (bus.data !== exp) begin
        fails++;
        $display("FAIL %s_read%0d: got %h, expected %h", tag, a, bus.data, exp);
      end
    end
  endtask

  // Runs a load from RUN using load_words. last_idx < 0 means load_last is
  // never set; start_before >= 0 pulses load_start (ignored) before that word.
  task automatic do_load(input int last_idx, input bit gapped, input int start_before, input string tag);
    int n = load_words.size();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    tests++; if (bus.load_ready !== 1'b1) begin fails++; $display("FAIL %s_ready_entry: got %b, expected 1", tag, bus.load_ready); end
    for (int i = 0; i < n; i++) begin
      if (gapped) begin
        bus.load_valid = 1'b0;
        tick();
      end
      if (i == start_before) begin
        bus.load_valid = 1'b0;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
      end
      bus.load_valid = 1'b1;
      bus.load_data  = load_words[i];
      bus.load_last  = (i == last_idx);
      tests++; if (bus.load_ready !== 1'b1) begin fails++; $display("FAIL %s_ready_w%0d: got %b, expected 1", tag, i, bus.load_ready); end
      tick();
      model[i] = load_words[i];
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    tests++; if (bus.hold !== 1'b0) begin fails++; $display("FAIL %s_hold_exit: got %b, expected 0", tag, bus.hold); end
    tests++; if (bus.load_ready !== 1'b0) begin fails++; $display("FAIL %s_ready_exit: got %b, expected 0", tag, bus.load_ready); end
    tests++; if (bus.loaded_len !== (ADDR_W + 1)'(n)) begin fails++; $display("FAIL %s_len: got %0d, expected %0d", tag, bus.loaded_len, n); end
    tests++; if (bus.data !== '0) begin fails++; $display("FAIL %s_nop: got %h, expected 00", tag, bus.data); end
  endtask

  task automatic test_reset();
    idle_inputs();
    n_reset = 1'b0;
    tick();
    apply_reset();
    run_clear(-1);
    read_all("powerup");
  endtask

  task automatic test_gapped_load();
    load_words = {8'hA1, 8'hB2, 8'hC3};
    do_load(2, 1'b1, -1, "gapped");
    read_all("gapped");
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] seq [3] = '{4'd0, 4'd1, 4'd0};
    logic [DATA_W-1:0] exp;
    for (int i = 0; i < 3; i++) begin
      bus.addr = seq[i];
      exp_q.push_back(model[seq[i]]);
      tick();
      exp = exp_q.pop_front();
      tests++; if (bus.data !== exp) begin fails++; $display("FAIL b2b_data%0d: got %h, expected %h", i, bus.data, exp); end
      tests++; if (bus.hold !== 1'b0) begin fails++; $display("FAIL b2b_hold%0d: got %b, expected 0", i, bus.hold); end
    end
  endtask

  task automatic test_start_ignored();
    // Single word with a start pulse inside LOAD: only mem[0] changes.
    load_words = {8'h55};
    do_load(0, 1'b0, 0, "single");
    read_all("single");
    // Start pulse between two words: the pointer must keep advancing.
    load_words = {8'h66, 8'h77};
    do_load(1, 1'b0, 1, "midstart");
    read_all("midstart");
  endtask

  task automatic test_full_load();
    load_words.delete();
    for (int i = 0; i < DEPTH; i++) load_words.push_back(8'h10 + 8'(i));
    do_load(-1, 1'b0, -1, "full");
    read_all("full");
  endtask

  task automatic test_clear_ignores_start();
    apply_reset();
    run_clear(5);
    read_all("clrstart");
  endtask

  task automatic test_reset_mid_load();
    load_words = {8'hD1, 8'hD2, 8'hD3, 8'hD4};
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = load_words[i];
      tick();
    end
    // Keep a word valid across the reset edge: reset must win.
    bus.load_data = load_words[2];
    apply_reset();
    idle_inputs();
    run_clear(-1);
    read_all("abort");
    tests++; if (bus.loaded_len !== '0) begin fails++; $display("FAIL abort_len: got %0d, expected 0", bus.loaded_len); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_gapped_load();
    test_back_to_back();
    test_start_ignored();
    test_full_load();
    test_clear_ignores_start();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
